// File: rtl/supreme_es.sv
// supreme_es -- step-command encoder for the 3-phase position bus.
//
// This block queues single-cycle left/right step requests into a saturating
// signed pending count. It replays each queued step as one phase change on
// phase_p. A right step advances 0->1->2->0 and a left step retreats
// 0->2->1->0. After every change the new phase is held for DWELL cycles so
// that the far-end decoder samples it reliably.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   1: emit queued steps, 0: freeze emission (queueing continues)
//   left_req   in   one-cycle request for one left step
//   right_req  in   one-cycle request for one right step
//   flush      in   synchronous clear of the pending queue
//   phase_p    out  current phase, 0..2
//   step_pulse out  one-cycle pulse on the cycle phase_p changes
//   busy       out  steps pending or a step/dwell in progress
//   drop       out  one-cycle pulse when a request is lost to saturation
module supreme_es #(
   parameter int DWELL    = 16,
   parameter int PEND_MAX = 7,
   parameter int PEND_W   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       left_req,
   input  logic       right_req,
   input  logic       flush,
   output logic [2:0] phase_p,
   output logic       step_pulse,
   output logic       busy,
   output logic       drop
);

   localparam int                     DW_W       = $clog2(DWELL);
   localparam logic [DW_W-1:0]        DWELL_LOAD = DW_W'(DWELL - 1);
   localparam logic [DW_W-1:0]        DW_ONE     = DW_W'(1);
   localparam logic signed [PEND_W:0] PMAX       = (PEND_W + 1)'(PEND_MAX);
   localparam logic signed [PEND_W:0] PMIN       = -PMAX;
   localparam logic signed [PEND_W:0] ONE        = (PEND_W + 1)'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_STEP = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [2:0]               phase_q, phase_d;
   logic [DW_W-1:0]          dwell_q, dwell_d;
   logic signed [PEND_W-1:0] pend_q, pend_d;
   logic                     step_pulse_q, step_pulse_d;
   logic                     busy_q, busy_d;
   logic                     drop_q, drop_d;

   logic                     emit;
   logic                     pend_pos;
   logic signed [PEND_W:0]   pend_ext, req_delta, emit_delta, pend_sum;

   always_comb begin
      state_d      = state_q;
      phase_d      = phase_q;
      dwell_d      = dwell_q;
      step_pulse_d = 1'b0;
      drop_d       = 1'b0;
      emit         = 1'b0;
      pend_pos     = !pend_q[PEND_W-1] && (pend_q != '0);

      // The phase update is registered together with the IDLE->STEP
      // transition. The new phase is therefore visible during the STEP cycle,
      // which gives the request-to-change latency of two cycles.
      case (state_q)
         S_IDLE: begin
            if (en && (pend_q != '0)) begin
               emit         = 1'b1;
               step_pulse_d = 1'b1;
               state_d      = S_STEP;
               if (pend_pos) phase_d = (phase_q == 3'd2) ? 3'd0 : phase_q + 3'd1;
               else          phase_d = (phase_q == 3'd0) ? 3'd2 : phase_q - 3'd1;
            end
         end
         S_STEP: begin
            dwell_d = DWELL_LOAD;
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (dwell_q == '0) state_d = S_IDLE;
            else               dwell_d = dwell_q - DW_ONE;
         end
         default: state_d = S_IDLE;
      endcase

      // Simultaneous left and right requests cancel. Emission always moves
      // the count toward zero, so only a request can push it past the clamp.
      pend_ext   = {pend_q[PEND_W-1], pend_q};
      req_delta  = (right_req && !left_req) ? ONE :
                   (left_req && !right_req) ? -ONE : '0;
      emit_delta = !emit ? '0 : (pend_pos ? ONE : -ONE);
      pend_sum   = pend_ext + req_delta - emit_delta;

      if (flush) begin
         pend_d = '0;
      end else if (pend_sum > PMAX) begin
         pend_d = PMAX[PEND_W-1:0];
         drop_d = 1'b1;
      end else if (pend_sum < PMIN) begin
         pend_d = PMIN[PEND_W-1:0];
         drop_d = 1'b1;
      end else begin
         pend_d = pend_sum[PEND_W-1:0];
      end

      busy_d = (pend_d != '0) || (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         phase_q      <= 3'd0;
         dwell_q      <= '0;
         pend_q       <= '0;
         step_pulse_q <= 1'b0;
         busy_q       <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         dwell_q      <= dwell_d;
         pend_q       <= pend_d;
         step_pulse_q <= step_pulse_d;
         busy_q       <= busy_d;
         drop_q       <= drop_d;
      end
   end

   assign phase_p    = phase_q;
   assign step_pulse = step_pulse_q;
   assign busy       = busy_q;
   assign drop       = drop_q;

endmodule

// File: tb/tb_supreme_es.sv
// Testbench for supreme_es.
//
// The reference model works at the level of step transactions. It holds a
// signed pending count, the current phase, and the cycle of the last phase
// change. A new step may only be issued once DWELL+2 cycles have passed
// since the previous one.
module tb_supreme_es;

   localparam int DWELL = 16;
   localparam int PM    = 7;
   localparam int PW    = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0, left_req = 1'b0, right_req = 1'b0, flush = 1'b0;
   logic [2:0] phase_p;
   logic       step_pulse, busy, drop;

   int checks = 0;
   int passed = 0;

   // reference model state: values expected on the outputs in cycle cyc
   int cyc, m_pend, m_phase, m_last;
   bit m_pulse, m_busy, m_drop;

   supreme_es #(.DWELL(DWELL), .PEND_MAX(PM), .PEND_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .left_req(left_req),
      .right_req(right_req), .flush(flush), .phase_p(phase_p),
      .step_pulse(step_pulse), .busy(busy), .drop(drop)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      cyc = 0; m_pend = 0; m_phase = 0; m_last = -1000;
      m_pulse = 0; m_busy = 0; m_drop = 0;
   endtask

   // Advance the model by one cycle, given the inputs applied during cycle cyc.
   task automatic model_step(input bit e, input bit l, input bit r, input bit f);
      int d, np;
      m_pulse = 0;
      m_drop  = 0;
      if (e && m_pend != 0 && cyc >= m_last + DWELL + 1) begin
         d       = (m_pend > 0) ? 1 : -1;
         m_phase = (m_phase + d + 3) % 3;
         m_pend  = m_pend - d;
         m_last  = cyc + 1;
         m_pulse = 1;
      end
      if (f) begin
         m_pend = 0;
      end else if (l != r) begin
         np = m_pend + (r ? 1 : -1);
         if (np > PM)       begin np = PM;  m_drop = 1; end
         else if (np < -PM) begin np = -PM; m_drop = 1; end
         m_pend = np;
      end
      cyc    = cyc + 1;
      m_busy = (m_pend != 0) || (cyc <= m_last + DWELL);
   endtask

   // Called just after a negedge; returns at the next negedge.
   task automatic drive(input bit e, input bit l, input bit r, input bit f);
      en = e; left_req = l; right_req = r; flush = f;
      model_step(e, l, r, f);
      @(negedge clk);
   endtask

   task automatic do_reset();
      en = 0; left_req = 0; right_req = 0; flush = 0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      @(negedge clk);
      if ({phase_p, step_pulse, busy, drop} !== 6'b0) begin
         $display("FAIL reset_state got %b want 000000", {phase_p, step_pulse, busy, drop});
      end else passed++;
      checks++;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_right_burst();
      int pulses = 0, lastp = -1;
      for (int i = 0; i < 4 + 4 * (DWELL + 2) + 6; i++) begin
         drive(1, 0, i < 4, 0);
         if ({phase_p, step_pulse, busy, drop} !== {3'(m_phase), m_pulse, m_busy, m_drop}) begin
            $display("FAIL right_burst cyc=%0d got ph/pulse/busy/drop=%0d/%b/%b/%b want %0d/%b/%b/%b",
                     cyc, phase_p, step_pulse, busy, drop, m_phase, m_pulse, m_busy, m_drop);
         end else passed++;
         checks++;
         if (step_pulse === 1'b1) begin
            if (lastp >= 0) begin
               if (cyc - lastp !== DWELL + 2) begin
                  $display("FAIL right_spacing got %0d want %0d", cyc - lastp, DWELL + 2);
               end else passed++;
               checks++;
            end
            lastp = cyc;
            pulses++;
         end
      end
      if (pulses !== 4) $display("FAIL right_pulses got %0d want 4", pulses);
      else passed++;
      checks++;
      if ({phase_p, busy} !== {3'd1, 1'b0}) $display("FAIL right_final got ph=%0d busy=%b want 1/0", phase_p, busy);
      else passed++;
      checks++;
   endtask

   task automatic test_left();
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 2 + 2 * (DWELL + 2) + 6; i++) begin
         drive(1, i < 2, 0, 0);
         if ({phase_p, step_pulse, busy, drop} !== {3'(m_phase), m_pulse, m_busy, m_drop}) begin
            $display("FAIL left cyc=%0d got ph/pulse/busy/drop=%0d/%b/%b/%b want %0d/%b/%b/%b",
                     cyc, phase_p, step_pulse, busy, drop, m_phase, m_pulse, m_busy, m_drop);
         end else passed++;
         checks++;
         if (step_pulse === 1'b1) pulses++;
      end
      if ({pulses, phase_p} !== {32'd2, 3'd1}) $display("FAIL left_final got pulses=%0d ph=%0d want 2/1", pulses, phase_p);
      else passed++;
      checks++;
   endtask

   task automatic test_saturate();
      int pulses = 0, drops = 0;
      do_reset();
      for (int i = 0; i < 12 + 7 * (DWELL + 2) + 6; i++) begin
         drive(i >= 12, 0, i < 10, 0);
         if ({phase_p, step_pulse, busy, drop} !== {3'(m_phase), m_pulse, m_busy, m_drop}) begin
            $display("FAIL saturate cyc=%0d got ph/pulse/busy/drop=%0d/%b/%b/%b want %0d/%b/%b/%b",
                     cyc, phase_p, step_pulse, busy, drop, m_phase, m_pulse, m_busy, m_drop);
         end else passed++;
         checks++;
         if (step_pulse === 1'b1) pulses++;
         if (drop === 1'b1) drops++;
      end
      if (drops !== 3) $display("FAIL sat_drops got %0d want 3", drops);
      else passed++;
      checks++;
      if (pulses !== 7) $display("FAIL sat_steps got %0d want 7", pulses);
      else passed++;
      checks++;
   endtask

   task automatic test_cancel();
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 8 + 2 * (DWELL + 2) + 6; i++) begin
         drive(1, (i == 0) || (i == 7), (i == 0) || (i >= 4 && i <= 6), 0);
         if ({phase_p, step_pulse, busy, drop} !== {3'(m_phase), m_pulse, m_busy, m_drop}) begin
            $display("FAIL cancel cyc=%0d got ph/pulse/busy/drop=%0d/%b/%b/%b want %0d/%b/%b/%b",
                     cyc, phase_p, step_pulse, busy, drop, m_phase, m_pulse, m_busy, m_drop);
         end else passed++;
         checks++;
         if (i < 4 && busy !== 1'b0) begin
            $display("FAIL cancel_busy cyc=%0d got %b want 0", cyc, busy);
         end
         if (step_pulse === 1'b1) pulses++;
      end
      if (pulses !== 2) $display("FAIL cancel_steps got %0d want 2", pulses);
      else passed++;
      checks++;
   endtask

   task automatic test_flush();
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 50; i++) begin
         drive(1, 0, (i < 6) || (i == 40), (i == 10) || (i == 40));
         if ({phase_p, step_pulse, busy, drop} !== {3'(m_phase), m_pulse, m_busy, m_drop}) begin
            $display("FAIL flush cyc=%0d got ph/pulse/busy/drop=%0d/%b/%b/%b want %0d/%b/%b/%b",
                     cyc, phase_p, step_pulse, busy, drop, m_phase, m_pulse, m_busy, m_drop);
         end else passed++;
         checks++;
         if (step_pulse === 1'b1) pulses++;
      end
      if ({pulses, busy} !== {32'd1, 1'b0}) $display("FAIL flush_final got pulses=%0d busy=%b want 1/0", pulses, busy);
      else passed++;
      checks++;
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      for (int i = 0; i < 26; i++) begin
         drive(1, 0, i < 2, 0);
         if ({phase_p, step_pulse, busy, drop} !== {3'(m_phase), m_pulse, m_busy, m_drop}) begin
            $display("FAIL pre_reset cyc=%0d got ph/pulse/busy/drop=%0d/%b/%b/%b want %0d/%b/%b/%b",
                     cyc, phase_p, step_pulse, busy, drop, m_phase, m_pulse, m_busy, m_drop);
         end else passed++;
         checks++;
      end
      if ({phase_p, busy} !== {3'd2, 1'b1}) $display("FAIL hold_setup got ph=%0d busy=%b want 2/1", phase_p, busy);
      else passed++;
      checks++;
      #2 rst_n = 1'b0;
      #1;
      if ({phase_p, step_pulse, busy, drop} !== 6'b0) begin
         $display("FAIL async_reset got %b want 000000", {phase_p, step_pulse, busy, drop});
      end else passed++;
      checks++;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_random();
      bit e, l, r, f;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         e = (i % 400 < 300) ? ($urandom_range(0, 3) != 0) : 1'b0;
         l = ($urandom_range(0, 5) == 0);
         r = ($urandom_range(0, 4) == 0);
         f = ($urandom_range(0, 59) == 0);
         drive(e, l, r, f);
         if ({phase_p, step_pulse, busy, drop} !== {3'(m_phase), m_pulse, m_busy, m_drop}) begin
            $display("FAIL random cyc=%0d got ph/pulse/busy/drop=%0d/%b/%b/%b want %0d/%b/%b/%b",
                     cyc, phase_p, step_pulse, busy, drop, m_phase, m_pulse, m_busy, m_drop);
         end else passed++;
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_right_burst();
      test_left();
      test_saturate();
      test_cancel();
      test_flush();
      test_reset_mid_hold();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
